// File: rtl/noc_common_mem_fifo_pkg.sv
//----------------------------------------------------------------------------
// Module  : noc_common_mem_fifo_pkg
// Brief   : Shared constants and types for the NoC memory-backed FIFO.
// Revision: 1.0 - initial release
//----------------------------------------------------------------------------
`default_nettype none

package noc_common_mem_fifo_pkg;

    localparam int OB_DEPTH       = 2;
    localparam int OB_CNTW        = $clog2(OB_DEPTH + 1);
    localparam int MEM_RD_LATENCY = 1;

    typedef logic [OB_CNTW-1:0] ob_cnt_t;

endpackage

`default_nettype wire

// File: rtl/noc_common_mem_fifo_ob.sv
//----------------------------------------------------------------------------
// Module  : noc_common_mem_fifo_ob
// Brief   : 2-entry registered output buffer, valid/ready on the pop side.
// Revision: 1.0 - initial release
//----------------------------------------------------------------------------
`default_nettype none

module noc_common_mem_fifo_ob
    import noc_common_mem_fifo_pkg::*;
#(
    parameter int DATAW = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic [DATAW-1:0] i_push_data,
    output logic             o_vld,
    input  logic             i_rdy,
    output logic [DATAW-1:0] o_data,
    output ob_cnt_t          o_cnt
);

    logic [DATAW-1:0] r_data [OB_DEPTH];
    ob_cnt_t          r_cnt;
    logic             w_pop;

    assign o_vld  = (r_cnt != '0);
    assign o_data = r_data[0];
    assign o_cnt  = r_cnt;
    assign w_pop  = o_vld && i_rdy;

    // Entry 0 is always the head; entry 1 shifts down on pop.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else begin
            case ({i_push, w_pop})
                2'b10: begin
                    if (r_cnt == '0) r_data[0] <= i_push_data;
                    else             r_data[1] <= i_push_data;
                    r_cnt <= r_cnt + OB_CNTW'(1);
                end
                2'b01: begin
                    r_data[0] <= r_data[1];
                    r_cnt     <= r_cnt - OB_CNTW'(1);
                end
                2'b11: begin
                    if (r_cnt == OB_CNTW'(1)) begin
                        r_data[0] <= i_push_data;
                    end else begin
                        r_data[0] <= r_data[1];
                        r_data[1] <= i_push_data;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: rtl/noc_common_mem_fifo_ctrl.sv
//----------------------------------------------------------------------------
// Module  : noc_common_mem_fifo_ctrl
// Brief   : Valid/ready FIFO controller driving a 1R1W memory wrapper.
// Revision: 1.0 - initial release
//----------------------------------------------------------------------------
`default_nettype none

module noc_common_mem_fifo_ctrl
    import noc_common_mem_fifo_pkg::*;
#(
    parameter int DATAW = 64,
    parameter int DEPTH = 32,
    parameter int ADDRW = $clog2(DEPTH),
    parameter int CNTW  = $clog2(DEPTH + 3)
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             WrVld,
    output logic             WrRdy,
    input  logic [DATAW-1:0] WrData,
    output logic             RdVld,
    input  logic             RdRdy,
    output logic [DATAW-1:0] RdData,
    output logic             MemRdEn,
    output logic [ADDRW-1:0] MemRdAddr,
    input  logic [DATAW-1:0] MemRdData,
    output logic             MemWrEn,
    output logic [ADDRW-1:0] MemWrAddr,
    output logic [DATAW-1:0] MemWrBitEn,
    output logic [DATAW-1:0] MemWrData,
    output logic [CNTW-1:0]  Count,
    output logic             Empty
);

    localparam int                      c_MEM_CNTW  = $clog2(DEPTH + 1);
    localparam logic [c_MEM_CNTW-1:0]   c_MEM_FULL  = c_MEM_CNTW'(DEPTH);
    localparam logic [ADDRW-1:0]        c_LAST_ADDR = ADDRW'(DEPTH - 1);

    generate
        if (MEM_RD_LATENCY != 1) begin : g_bad_rd_latency
            $error("noc_common_mem_fifo_ctrl supports a memory read latency of 1 only");
        end
    endgenerate

    logic [ADDRW-1:0]      r_wr_ptr;
    logic [ADDRW-1:0]      r_rd_ptr;
    logic [c_MEM_CNTW-1:0] r_mem_cnt;
    logic                  r_inflight;
    logic [CNTW-1:0]       r_count;

    logic                  w_push;
    logic                  w_pop;
    logic                  w_issue;
    ob_cnt_t               w_ob_cnt;
    ob_cnt_t               w_ob_cnt_nxt;
    logic [2:0]            w_occ;
    logic [c_MEM_CNTW-1:0] w_mem_cnt_nxt;

    assign WrRdy  = !Rst && (r_mem_cnt < c_MEM_FULL);
    assign w_push = WrVld && WrRdy;
    assign w_pop  = RdVld && RdRdy;

    // Credit rule: buffered plus in-flight words never exceed the buffer depth.
    assign w_occ   = 3'(w_ob_cnt) + 3'(r_inflight);
    assign w_issue = !Rst && (r_mem_cnt != '0) && (w_occ < (3'(OB_DEPTH) + 3'(w_pop)));

    assign w_mem_cnt_nxt = r_mem_cnt + c_MEM_CNTW'(w_push) - c_MEM_CNTW'(w_issue);
    assign w_ob_cnt_nxt  = w_ob_cnt + ob_cnt_t'(r_inflight) - ob_cnt_t'(w_pop);

    assign MemWrEn    = w_push;
    assign MemWrAddr  = r_wr_ptr;
    assign MemWrData  = WrData;
    assign MemWrBitEn = '1;
    assign MemRdEn    = w_issue;
    assign MemRdAddr  = r_rd_ptr;

    assign Count = r_count;
    assign Empty = (r_count == '0);

    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_mem_cnt  <= '0;
            r_inflight <= 1'b0;
            r_count    <= '0;
        end else begin
            if (w_push) r_wr_ptr <= (r_wr_ptr == c_LAST_ADDR) ? '0 : r_wr_ptr + ADDRW'(1);
            if (w_issue) r_rd_ptr <= (r_rd_ptr == c_LAST_ADDR) ? '0 : r_rd_ptr + ADDRW'(1);
            r_mem_cnt  <= w_mem_cnt_nxt;
            r_inflight <= w_issue;
            r_count    <= CNTW'(w_mem_cnt_nxt) + CNTW'(w_issue) + CNTW'(w_ob_cnt_nxt);
        end
    end

    // Read data from the macro is captured the cycle after issue.
    noc_common_mem_fifo_ob #(
        .DATAW (DATAW)
    ) u_ob (
        .clk         (Clk),
        .rst         (Rst),
        .i_push      (r_inflight),
        .i_push_data (MemRdData),
        .o_vld       (RdVld),
        .i_rdy       (RdRdy),
        .o_data      (RdData),
        .o_cnt       (w_ob_cnt)
    );

    a_no_push_when_full: assert property (@(posedge Clk) disable iff (Rst)
        !(MemWrEn && !WrRdy));
    a_rd_data_hold: assert property (@(posedge Clk) disable iff (Rst)
        (RdVld && !RdRdy) |=> $stable(RdData));
    a_mem_cnt_bound: assert property (@(posedge Clk) disable iff (Rst)
        r_mem_cnt <= c_MEM_FULL);
    a_no_addr_collision: assert property (@(posedge Clk) disable iff (Rst)
        !(MemWrEn && MemRdEn && (MemWrAddr == MemRdAddr)));

endmodule

`default_nettype wire

// File: tb/tb_noc_common_mem_fifo_ctrl.sv
//----------------------------------------------------------------------------
// Module  : tb_noc_common_mem_fifo_ctrl
// Brief   : Directed vector table plus scoreboarded streams for the FIFO ctrl.
// Revision: 1.0 - initial release
//----------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module tb_noc_common_mem_fifo_ctrl;

    localparam int DATAW = 8;
    localparam int DEPTH = 4;
    localparam int ADDRW = 2;
    localparam int CNTW  = 3;

    logic             Clk = 1'b0;
    logic             Rst = 1'b1;
    logic             WrVld = 1'b0;
    logic             WrRdy;
    logic [DATAW-1:0] WrData = '0;
    logic             RdVld;
    logic             RdRdy = 1'b0;
    logic [DATAW-1:0] RdData;
    logic             MemRdEn;
    logic [ADDRW-1:0] MemRdAddr;
    logic [DATAW-1:0] MemRdData = '0;
    logic             MemWrEn;
    logic [ADDRW-1:0] MemWrAddr;
    logic [DATAW-1:0] MemWrBitEn;
    logic [DATAW-1:0] MemWrData;
    logic [CNTW-1:0]  Count;
    logic             Empty;

    logic [DATAW-1:0] mem [DEPTH];

    int n_checks = 0;
    int n_err    = 0;

    always #5 Clk = ~Clk;

    noc_common_mem_fifo_ctrl #(
        .DATAW (DATAW),
        .DEPTH (DEPTH),
        .ADDRW (ADDRW),
        .CNTW  (CNTW)
    ) dut (
        .Clk        (Clk),
        .Rst        (Rst),
        .WrVld      (WrVld),
        .WrRdy      (WrRdy),
        .WrData     (WrData),
        .RdVld      (RdVld),
        .RdRdy      (RdRdy),
        .RdData     (RdData),
        .MemRdEn    (MemRdEn),
        .MemRdAddr  (MemRdAddr),
        .MemRdData  (MemRdData),
        .MemWrEn    (MemWrEn),
        .MemWrAddr  (MemWrAddr),
        .MemWrBitEn (MemWrBitEn),
        .MemWrData  (MemWrData),
        .Count      (Count),
        .Empty      (Empty)
    );

    // 1-cycle-latency memory model, read returns the pre-write contents.
    always @(posedge Clk) begin
        if (MemRdEn) MemRdData <= mem[MemRdAddr];
        if (MemWrEn) mem[MemWrAddr] <= MemWrData;
    end

    typedef struct {
        logic       rst;
        logic       wv;
        logic [7:0] wd;
        logic       rr;
        logic       chk;
        logic       wrdy;
        logic       wen;
        logic [1:0] waddr;
        logic       ren;
        logic [1:0] raddr;
        logic       rvld;
        logic [7:0] rdata;
        logic [2:0] cnt;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t V(int rst, int wv, int wd, int rr, int chk, int wrdy, int wen,
                               int waddr, int ren, int raddr, int rvld, int rdata, int cnt);
        vec_t v;
        v.rst = 1'(rst);   v.wv = 1'(wv);     v.wd = 8'(wd);       v.rr = 1'(rr);
        v.chk = 1'(chk);   v.wrdy = 1'(wrdy); v.wen = 1'(wen);     v.waddr = 2'(waddr);
        v.ren = 1'(ren);   v.raddr = 2'(raddr); v.rvld = 1'(rvld); v.rdata = 8'(rdata);
        v.cnt = 3'(cnt);
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step(input logic rst, input logic wv, input logic [7:0] wd, input logic rr);
        @(negedge Clk);
        Rst = rst; WrVld = wv; WrData = wd; RdRdy = rr;
        #1;
    endtask

    initial begin
        logic [7:0] q[$];
        int         sent;
        int         got;
        logic       prev_hold;
        logic [7:0] prev_data;
        logic       seen;

        // rst wv wd rr chk | wrdy wen waddr ren raddr rvld rdata cnt
        tbl.push_back(V(1,0,8'h00,0,0, 0,0,0, 0,0, 0,8'h00,0));
        tbl.push_back(V(1,1,8'hFF,0,1, 0,0,0, 0,0, 0,8'h00,0));
        // single word latency
        tbl.push_back(V(0,1,8'hA5,1,1, 1,1,0, 0,0, 0,8'h00,1'b0));
        tbl.push_back(V(0,0,8'h00,1,1, 1,0,0, 1,0, 0,8'h00,1));
        tbl.push_back(V(0,0,8'h00,1,1, 1,0,0, 0,0, 0,8'h00,1));
        tbl.push_back(V(0,0,8'h00,1,1, 1,0,0, 0,0, 1,8'hA5,1));
        tbl.push_back(V(0,0,8'h00,1,1, 1,0,0, 0,0, 0,8'h00,0));
        tbl.push_back(V(1,0,8'h00,0,1, 0,0,0, 0,0, 0,8'h00,0));
        tbl.push_back(V(1,0,8'h00,0,1, 0,0,0, 0,0, 0,8'h00,0));
        // fill to DEPTH+2 with the sink stalled
        tbl.push_back(V(0,1,8'h01,0,1, 1,1,0, 0,0, 0,8'h00,0));
        tbl.push_back(V(0,1,8'h02,0,1, 1,1,1, 1,0, 0,8'h00,1));
        tbl.push_back(V(0,1,8'h03,0,1, 1,1,2, 1,1, 0,8'h00,2));
        tbl.push_back(V(0,1,8'h04,0,1, 1,1,3, 0,0, 1,8'h01,3));
        tbl.push_back(V(0,1,8'h05,0,1, 1,1,0, 0,0, 1,8'h01,4));
        tbl.push_back(V(0,1,8'h06,0,1, 1,1,1, 0,0, 1,8'h01,5));
        tbl.push_back(V(0,1,8'h07,0,1, 0,0,0, 0,0, 1,8'h01,6));
        tbl.push_back(V(0,1,8'h07,0,1, 0,0,0, 0,0, 1,8'h01,6));
        // from full: one pop and one push per cycle, pointers wrap
        tbl.push_back(V(0,1,8'h07,1,1, 0,0,0, 1,2, 1,8'h01,6));
        tbl.push_back(V(0,1,8'h07,1,1, 1,1,2, 1,3, 1,8'h02,5));
        tbl.push_back(V(0,1,8'h08,1,1, 1,1,3, 1,0, 1,8'h03,5));
        tbl.push_back(V(0,1,8'h09,1,1, 1,1,0, 1,1, 1,8'h04,5));
        tbl.push_back(V(0,1,8'h0A,1,1, 1,1,1, 1,2, 1,8'h05,5));
        tbl.push_back(V(0,0,8'h00,1,1, 1,0,0, 1,3, 1,8'h06,5));
        tbl.push_back(V(0,0,8'h00,1,1, 1,0,0, 1,0, 1,8'h07,4));
        tbl.push_back(V(0,0,8'h00,1,1, 1,0,0, 1,1, 1,8'h08,3));
        tbl.push_back(V(0,0,8'h00,1,1, 1,0,0, 0,0, 1,8'h09,2));
        tbl.push_back(V(0,0,8'h00,1,1, 1,0,0, 0,0, 1,8'h0A,1));
        tbl.push_back(V(0,0,8'h00,1,1, 1,0,0, 0,0, 0,8'h00,0));

        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i].rst, tbl[i].wv, tbl[i].wd, tbl[i].rr);
            if (tbl[i].chk) begin
                chk($sformatf("v%0d_wrrdy", i), 32'(WrRdy), 32'(tbl[i].wrdy));
                chk($sformatf("v%0d_memwren", i), 32'(MemWrEn), 32'(tbl[i].wen));
                if (tbl[i].wen) begin
                    chk($sformatf("v%0d_memwraddr", i), 32'(MemWrAddr), 32'(tbl[i].waddr));
                    chk($sformatf("v%0d_memwrdata", i), 32'(MemWrData), 32'(tbl[i].wd));
                end
                chk($sformatf("v%0d_memrden", i), 32'(MemRdEn), 32'(tbl[i].ren));
                if (tbl[i].ren)
                    chk($sformatf("v%0d_memrdaddr", i), 32'(MemRdAddr), 32'(tbl[i].raddr));
                chk($sformatf("v%0d_rdvld", i), 32'(RdVld), 32'(tbl[i].rvld));
                if (tbl[i].rvld)
                    chk($sformatf("v%0d_rddata", i), 32'(RdData), 32'(tbl[i].rdata));
                chk($sformatf("v%0d_count", i), 32'(Count), 32'(tbl[i].cnt));
                chk($sformatf("v%0d_empty", i), 32'(Empty), 32'(tbl[i].cnt == 3'd0));
            end
        end
        chk("bit_en", 32'(MemWrBitEn), 32'h0000_00FF);

        // streaming: 100 words, both sides always ready
        step(1, 0, 8'h00, 0);
        step(1, 0, 8'h00, 0);
        sent = 0; got = 0; q.delete();
        for (int cyc = 0; cyc < 300 && got < 100; cyc++) begin
            step(0, sent < 100, 8'(sent + 8'h10), 1);
            if (WrVld && WrRdy) begin q.push_back(WrData); sent++; end
            if (cyc >= 3 && cyc < 103) chk("stream_vld", 32'(RdVld), 32'd1);
            if (RdVld && RdRdy) begin
                if (q.size() == 0) chk("stream_extra_pop", 32'd1, 32'd0);
                else chk("stream_data", 32'(RdData), 32'(q.pop_front()));
                got++;
            end
        end
        chk("stream_words", 32'(got), 32'd100);

        // random sink stalls and source gaps
        step(1, 0, 8'h00, 0);
        step(1, 0, 8'h00, 0);
        sent = 0; got = 0; q.delete(); prev_hold = 1'b0; prev_data = '0;
        for (int cyc = 0; cyc < 20000 && got < 1000; cyc++) begin
            step(0, (sent < 1000) && ($urandom_range(0, 3) != 0), 8'(sent * 7 + 3),
                 1'($urandom_range(0, 1)));
            if (prev_hold) begin
                chk("hold_vld", 32'(RdVld), 32'd1);
                chk("hold_data", 32'(RdData), 32'(prev_data));
            end
            if (WrVld && WrRdy) begin q.push_back(WrData); sent++; end
            if (RdVld && RdRdy) begin
                if (q.size() == 0) chk("rand_extra_pop", 32'd1, 32'd0);
                else chk("rand_data", 32'(RdData), 32'(q.pop_front()));
                got++;
            end
            prev_hold = RdVld && !RdRdy;
            prev_data = RdData;
        end
        chk("rand_words", 32'(got), 32'd1000);
        step(0, 0, 8'h00, 0);
        chk("rand_drained_count", 32'(Count), 32'd0);
        chk("rand_drained_empty", 32'(Empty), 32'd1);

        // reset with Count=5 and a read in flight
        step(1, 0, 8'h00, 0);
        step(1, 0, 8'h00, 0);
        for (int i = 0; i < 5; i++) step(0, 1, 8'(8'h50 + i), 0);
        step(0, 1, 8'h55, 1);
        step(1, 0, 8'h00, 0);
        chk("mr_count_before", 32'(Count), 32'd5);
        chk("mr_wrrdy_in_rst", 32'(WrRdy), 32'd0);
        step(0, 1, 8'h3C, 1);
        chk("mr_rdvld", 32'(RdVld), 32'd0);
        chk("mr_count", 32'(Count), 32'd0);
        chk("mr_empty", 32'(Empty), 32'd1);
        chk("mr_wrrdy", 32'(WrRdy), 32'd1);
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            step(0, 0, 8'h00, 1);
            if (RdVld) begin
                chk("mr_first_word", 32'(RdData), 32'h3C);
                seen = 1'b1;
            end
        end
        if (!seen) chk("mr_first_word_timeout", 32'd0, 32'd1);
        step(0, 0, 8'h00, 0);
        chk("mr_final_empty", 32'(Empty), 32'd1);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
